// File: rtl/ex_mem_pipe_reg.sv
// ex_mem_pipe_reg
// ----------------
// EX->MEM pipeline boundary register. It carries the execute-stage result
// bundle (rd, store data, ALU/CFU result, pc+4, LSU op, write-back controls)
// to the memory stage under a valid/ready handshake.
//
// SKID=1 builds a 2-entry skid buffer. in_ready comes straight from a flop,
//        so the upstream ready path has no combinational logic.
// SKID=0 builds a single register. in_ready = ~out_valid | out_ready.
//
// Ports:
//   clk, arst_n        clock; asynchronous active-low reset
//   flush              drops all held entries and any same-cycle input transfer
//   in_valid/in_ready  upstream handshake
//   in_*               execute-stage bundle
//   out_valid/out_ready downstream handshake
//   out_*              registered bundle (the main entry)
//   occupancy          number of held entries (0..2)

module ex_mem_pipe_reg #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned LSUOP_W = 4,
    parameter int unsigned SKID    = 1
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               flush,

    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         in_rd,
    input  logic [XLEN-1:0]    in_opr_b,
    input  logic [XLEN-1:0]    in_opr_res,
    input  logic [XLEN-1:0]    in_pc4,
    input  logic [LSUOP_W-1:0] in_lsuop,
    input  logic               in_rf_en,
    input  logic               in_dm_en,
    input  logic [1:0]         in_wb_sel,

    output logic               out_valid,
    input  logic               out_ready,
    output logic [4:0]         out_rd,
    output logic [XLEN-1:0]    out_opr_b,
    output logic [XLEN-1:0]    out_opr_res,
    output logic [XLEN-1:0]    out_pc4,
    output logic [LSUOP_W-1:0] out_lsuop,
    output logic               out_rf_en,
    output logic               out_dm_en,
    output logic [1:0]         out_wb_sel,

    output logic [1:0]         occupancy
);

    typedef struct packed {
        logic [4:0]         rd;
        logic [XLEN-1:0]    opr_b;
        logic [XLEN-1:0]    opr_res;
        logic [XLEN-1:0]    pc4;
        logic [LSUOP_W-1:0] lsuop;
        logic               rf_en;
        logic               dm_en;
        logic [1:0]         wb_sel;
    } bundle_t;

    bundle_t in_bundle;
    bundle_t main_q, main_d;
    bundle_t skid_q, skid_d;
    logic    main_valid_q, main_valid_d;
    logic    skid_valid_q, skid_valid_d;
    logic    in_ready_q, in_ready_d;
    logic    xfer_in, xfer_out;

    assign in_bundle = '{rd:      in_rd,
                         opr_b:   in_opr_b,
                         opr_res: in_opr_res,
                         pc4:     in_pc4,
                         lsuop:   in_lsuop,
                         rf_en:   in_rf_en,
                         dm_en:   in_dm_en,
                         wb_sel:  in_wb_sel};

    assign in_ready = (SKID != 0) ? in_ready_q : (~main_valid_q | out_ready);
    assign xfer_in  = in_valid & in_ready;
    assign xfer_out = main_valid_q & out_ready;

    always_comb begin
        // NOTE: every signal gets its hold value first so that no path through
        // the branches below leaves one unassigned and infers a latch.
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;

        if (flush) begin
            // Flush wins: a same-cycle input is dropped, payloads are left alone.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (SKID == 0) begin
            if (xfer_in) begin
                main_d       = in_bundle;
                main_valid_d = 1'b1;
            end else if (xfer_out) begin
                main_valid_d = 1'b0;
            end
        end else begin
            unique case ({main_valid_q, skid_valid_q})
                2'b00: begin
                    if (xfer_in) begin
                        main_d       = in_bundle;
                        main_valid_d = 1'b1;
                    end
                end
                2'b10: begin
                    if (xfer_in && xfer_out) begin
                        main_d = in_bundle;
                    end else if (xfer_in) begin
                        // Downstream stalled: park the new bundle behind main.
                        skid_d       = in_bundle;
                        skid_valid_d = 1'b1;
                    end else if (xfer_out) begin
                        main_valid_d = 1'b0;
                    end
                end
                2'b11: begin
                    // in_ready is low here, so only a drain can happen.
                    if (xfer_out) begin
                        main_d       = skid_q;
                        skid_valid_d = 1'b0;
                    end
                end
                default: begin
                    // {0,1} is unreachable; hold.
                end
            endcase
        end

        // Registered ready: next cycle we can accept iff the skid slot is free.
        in_ready_d = ~skid_valid_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            // NOTE: payloads are reset too, so out_* reads as 0 after reset
            // and no stale bundle survives an asynchronous reset.
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

    assign out_valid   = main_valid_q;
    assign out_rd      = main_q.rd;
    assign out_opr_b   = main_q.opr_b;
    assign out_opr_res = main_q.opr_res;
    assign out_pc4     = main_q.pc4;
    assign out_lsuop   = main_q.lsuop;
    assign out_rf_en   = main_q.rf_en;
    assign out_dm_en   = main_q.dm_en;
    assign out_wb_sel  = main_q.wb_sel;

    assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Bench for ex_mem_pipe_reg: one SKID=1/XLEN=32 instance and one
// SKID=0/XLEN=64 instance, each compared every cycle against a FIFO model.

module tb_ex_mem_pipe_reg;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] opr_b;
        logic [63:0] opr_res;
        logic [63:0] pc4;
        logic [3:0]  lsuop;
        logic        rf_en;
        logic        dm_en;
        logic [1:0]  wb_sel;
    } bundle_t;

    logic clk    = 1'b0;
    logic arst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // ---------------- SKID=1, XLEN=32 instance ----------------
    logic        s_flush = 0, s_in_valid = 0, s_out_ready = 0;
    logic [4:0]  s_in_rd = 0;
    logic [31:0] s_in_opr_b = 0, s_in_opr_res = 0, s_in_pc4 = 0;
    logic [3:0]  s_in_lsuop = 0;
    logic        s_in_rf_en = 0, s_in_dm_en = 0;
    logic [1:0]  s_in_wb_sel = 0;
    logic        s_in_ready, s_out_valid, s_out_rf_en, s_out_dm_en;
    logic [4:0]  s_out_rd;
    logic [31:0] s_out_opr_b, s_out_opr_res, s_out_pc4;
    logic [3:0]  s_out_lsuop;
    logic [1:0]  s_out_wb_sel, s_occupancy;

    ex_mem_pipe_reg #(.XLEN(32), .LSUOP_W(4), .SKID(1)) u_skid (
        .clk(clk), .arst_n(arst_n), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_rd(s_in_rd),
        .in_opr_b(s_in_opr_b), .in_opr_res(s_in_opr_res), .in_pc4(s_in_pc4),
        .in_lsuop(s_in_lsuop), .in_rf_en(s_in_rf_en), .in_dm_en(s_in_dm_en),
        .in_wb_sel(s_in_wb_sel),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_rd(s_out_rd),
        .out_opr_b(s_out_opr_b), .out_opr_res(s_out_opr_res), .out_pc4(s_out_pc4),
        .out_lsuop(s_out_lsuop), .out_rf_en(s_out_rf_en), .out_dm_en(s_out_dm_en),
        .out_wb_sel(s_out_wb_sel), .occupancy(s_occupancy));

    // ---------------- SKID=0, XLEN=64 instance ----------------
    logic        n_flush = 0, n_in_valid = 0, n_out_ready = 0;
    logic [4:0]  n_in_rd = 0;
    logic [63:0] n_in_opr_b = 0, n_in_opr_res = 0, n_in_pc4 = 0;
    logic [3:0]  n_in_lsuop = 0;
    logic        n_in_rf_en = 0, n_in_dm_en = 0;
    logic [1:0]  n_in_wb_sel = 0;
    logic        n_in_ready, n_out_valid, n_out_rf_en, n_out_dm_en;
    logic [4:0]  n_out_rd;
    logic [63:0] n_out_opr_b, n_out_opr_res, n_out_pc4;
    logic [3:0]  n_out_lsuop;
    logic [1:0]  n_out_wb_sel, n_occupancy;

    ex_mem_pipe_reg #(.XLEN(64), .LSUOP_W(4), .SKID(0)) u_noskid (
        .clk(clk), .arst_n(arst_n), .flush(n_flush),
        .in_valid(n_in_valid), .in_ready(n_in_ready), .in_rd(n_in_rd),
        .in_opr_b(n_in_opr_b), .in_opr_res(n_in_opr_res), .in_pc4(n_in_pc4),
        .in_lsuop(n_in_lsuop), .in_rf_en(n_in_rf_en), .in_dm_en(n_in_dm_en),
        .in_wb_sel(n_in_wb_sel),
        .out_valid(n_out_valid), .out_ready(n_out_ready), .out_rd(n_out_rd),
        .out_opr_b(n_out_opr_b), .out_opr_res(n_out_opr_res), .out_pc4(n_out_pc4),
        .out_lsuop(n_out_lsuop), .out_rf_en(n_out_rf_en), .out_dm_en(n_out_dm_en),
        .out_wb_sel(n_out_wb_sel), .occupancy(n_occupancy));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- Models: ordered FIFO of bundles ----------------
    // SKID=1: capacity 2, ready is "fewer than 2 held" as of the last edge.
    // SKID=0: capacity 1, ready is "empty now, or downstream takes it now".
    bundle_t s_q[$];
    bundle_t n_q[$];
    logic    s_rdy_m = 1'b1;

    function automatic bundle_t cur_s();
        bundle_t b;
        b.rd = s_in_rd; b.opr_b = 64'(s_in_opr_b); b.opr_res = 64'(s_in_opr_res);
        b.pc4 = 64'(s_in_pc4); b.lsuop = s_in_lsuop; b.rf_en = s_in_rf_en;
        b.dm_en = s_in_dm_en; b.wb_sel = s_in_wb_sel;
        return b;
    endfunction

    function automatic bundle_t cur_n();
        bundle_t b;
        b.rd = n_in_rd; b.opr_b = n_in_opr_b; b.opr_res = n_in_opr_res;
        b.pc4 = n_in_pc4; b.lsuop = n_in_lsuop; b.rf_en = n_in_rf_en;
        b.dm_en = n_in_dm_en; b.wb_sel = n_in_wb_sel;
        return b;
    endfunction

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            s_q.delete();
            n_q.delete();
            s_rdy_m = 1'b1;
        end else begin
            bit s_in, s_out, n_in, n_out;
            s_in  = s_in_valid && s_rdy_m;
            s_out = (s_q.size() > 0) && s_out_ready;
            n_in  = n_in_valid && ((n_q.size() == 0) || n_out_ready);
            n_out = (n_q.size() > 0) && n_out_ready;
            if (s_flush) s_q.delete();
            else begin
                if (s_out) void'(s_q.pop_front());
                if (s_in) s_q.push_back(cur_s());
            end
            if (n_flush) n_q.delete();
            else begin
                if (n_out) void'(n_q.pop_front());
                if (n_in) n_q.push_back(cur_n());
            end
            s_rdy_m = (s_q.size() < 2);
        end
    end

    // ---------------- Compare process (away from the active edge) ----------------
    always @(negedge clk) begin
        check("s_out_valid", 64'(s_out_valid), 64'(s_q.size() > 0));
        check("s_occupancy", 64'(s_occupancy), 64'(s_q.size()));
        check("s_in_ready",  64'(s_in_ready),  64'(s_rdy_m));
        if (s_q.size() > 0) begin
            check("s_out_rd",      64'(s_out_rd),      64'(s_q[0].rd));
            check("s_out_opr_b",   64'(s_out_opr_b),   s_q[0].opr_b);
            check("s_out_opr_res", 64'(s_out_opr_res), s_q[0].opr_res);
            check("s_out_pc4",     64'(s_out_pc4),     s_q[0].pc4);
            check("s_out_ctl", {56'b0, s_out_lsuop, s_out_rf_en, s_out_dm_en, s_out_wb_sel},
                  {56'b0, s_q[0].lsuop, s_q[0].rf_en, s_q[0].dm_en, s_q[0].wb_sel});
        end
        check("n_out_valid", 64'(n_out_valid), 64'(n_q.size() > 0));
        check("n_occupancy", 64'(n_occupancy), 64'(n_q.size()));
        check("n_in_ready",  64'(n_in_ready),  64'((n_q.size() == 0) || n_out_ready));
        if (n_q.size() > 0) begin
            check("n_out_rd",      64'(n_out_rd), 64'(n_q[0].rd));
            check("n_out_opr_b",   n_out_opr_b,   n_q[0].opr_b);
            check("n_out_opr_res", n_out_opr_res, n_q[0].opr_res);
            check("n_out_pc4",     n_out_pc4,     n_q[0].pc4);
            check("n_out_ctl", {56'b0, n_out_lsuop, n_out_rf_en, n_out_dm_en, n_out_wb_sel},
                  {56'b0, n_q[0].lsuop, n_q[0].rf_en, n_q[0].dm_en, n_q[0].wb_sel});
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Side fields are derived from opr_res so every field carries distinct data.
    task automatic set_s(input logic v, input logic [31:0] res, input logic [4:0] rd);
        s_in_valid   = v;
        s_in_opr_res = res;
        s_in_rd      = rd;
        s_in_opr_b   = ~res;
        s_in_pc4     = res + 32'd4;
        s_in_lsuop   = res[3:0];
        s_in_rf_en   = res[0];
        s_in_dm_en   = res[1];
        s_in_wb_sel  = res[3:2];
    endtask

    task automatic set_n(input logic v, input logic [63:0] b, input logic [63:0] res,
                         input logic [63:0] pc4);
        n_in_valid   = v;
        n_in_opr_b   = b;
        n_in_opr_res = res;
        n_in_pc4     = pc4;
        n_in_rd      = res[4:0];
        n_in_lsuop   = res[7:4];
        n_in_rf_en   = res[0];
        n_in_dm_en   = res[1];
        n_in_wb_sel  = res[3:2];
    endtask

    logic [11:0] n_pat = 12'b1011_0010_1101;

    initial begin
        // Reset
        #2 arst_n = 1'b0;
        #1;
        check("rst_s_in_ready",  64'(s_in_ready), 64'd1);
        check("rst_s_out_valid", 64'(s_out_valid), 64'd0);
        check("rst_s_opr_res",   64'(s_out_opr_res), 64'd0);
        check("rst_n_in_ready",  64'(n_in_ready), 64'd1);
        check("rst_n_opr_b",     n_out_opr_b, 64'd0);
        tick(); tick();
        arst_n = 1'b1;
        tick();
        check("post_rst_s_in_ready", 64'(s_in_ready), 64'd1);

        // Streaming, SKID=1
        s_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_s(1'b1, 32'h10 + 32'(i), 5'(i + 1));
            tick();
            check("stream_valid",   64'(s_out_valid), 64'd1);
            check("stream_opr_res", 64'(s_out_opr_res), 64'h10 + 64'(i));
        end
        set_s(1'b0, 32'h0, 5'd0);
        tick();
        check("stream_drained", 64'(s_out_valid), 64'd0);

        // Backpressure, SKID=1
        s_out_ready = 1'b0;
        set_s(1'b1, 32'hA, 5'd10); tick();
        set_s(1'b1, 32'hB, 5'd11); tick();
        check("bp_out_a",   64'(s_out_opr_res), 64'hA);
        check("bp_occ2",    64'(s_occupancy), 64'd2);
        check("bp_ready0",  64'(s_in_ready), 64'd0);
        set_s(1'b1, 32'hC, 5'd12); tick();
        check("bp_c_held",  64'(s_occupancy), 64'd2);
        s_out_ready = 1'b1; tick();
        check("bp_out_b",   64'(s_out_opr_res), 64'hB);
        check("bp_ready1",  64'(s_in_ready), 64'd1);
        tick();
        check("bp_out_c",   64'(s_out_opr_res), 64'hC);
        set_s(1'b0, 32'h0, 5'd0); tick();
        check("bp_empty",   64'(s_out_valid), 64'd0);

        // Flush on FULL with in_valid high
        s_out_ready = 1'b0;
        set_s(1'b1, 32'h20, 5'd1); tick();
        set_s(1'b1, 32'h21, 5'd2); tick();
        set_s(1'b1, 32'h22, 5'd3);
        s_flush = 1'b1; tick();
        s_flush = 1'b0;
        set_s(1'b0, 32'h0, 5'd0);
        check("flush_full_valid", 64'(s_out_valid), 64'd0);
        check("flush_full_occ",   64'(s_occupancy), 64'd0);
        check("flush_full_ready", 64'(s_in_ready), 64'd1);
        s_out_ready = 1'b1;
        tick(); tick();
        check("flush_full_gone", 64'(s_out_valid), 64'd0);

        // Flush with a transfer in at ONE
        s_out_ready = 1'b0;
        set_s(1'b1, 32'h30, 5'd4); tick();
        set_s(1'b1, 32'h123, 5'd5);
        s_flush = 1'b1; tick();
        s_flush = 1'b0;
        set_s(1'b0, 32'h0, 5'd0);
        check("flush_one_valid", 64'(s_out_valid), 64'd0);
        s_out_ready = 1'b1; tick();
        check("flush_one_gone", 64'(s_out_valid), 64'd0);

        // Asynchronous reset while FULL
        s_out_ready = 1'b0;
        set_s(1'b1, 32'h40, 5'd6); tick();
        set_s(1'b1, 32'h41, 5'd7); tick();
        set_s(1'b0, 32'h0, 5'd0);
        check("pre_rst_occ", 64'(s_occupancy), 64'd2);
        #2 arst_n = 1'b0;
        #1;
        check("mid_rst_valid",   64'(s_out_valid), 64'd0);
        check("mid_rst_occ",     64'(s_occupancy), 64'd0);
        check("mid_rst_opr_res", 64'(s_out_opr_res), 64'd0);
        check("mid_rst_ready",   64'(s_in_ready), 64'd1);
        tick();
        arst_n = 1'b1;
        s_out_ready = 1'b1;
        tick();
        check("post_mid_rst_valid", 64'(s_out_valid), 64'd0);

        // SKID=0, 64-bit payload, toggling out_ready
        n_out_ready = 1'b0;
        set_n(1'b1, 64'hFFFF_0000_1234_5678, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        check("n_opr_b_lit",   n_out_opr_b, 64'hFFFF_0000_1234_5678);
        check("n_pc4_lit",     n_out_pc4,   64'hFFFF_FFFF_FFFF_FFFC);
        check("n_ready_stall", 64'(n_in_ready), 64'd0);
        n_out_ready = 1'b1;
        #1;
        check("n_ready_comb",  64'(n_in_ready), 64'd1);
        for (int i = 0; i < 12; i++) begin
            n_out_ready = n_pat[i];
            set_n(1'b1, 64'hFFFF_0000_1234_5678 + 64'(i), 64'hDEAD_BEEF_0000_0000 | 64'(i * 17),
                  64'h8000_0000_0000_0004 + 64'(i << 2));
            tick();
        end
        set_n(1'b0, 64'h0, 64'h0, 64'h0);
        n_out_ready = 1'b1;
        tick(); tick();
        check("n_drained", 64'(n_out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mem_pipe_reg.md
# ex_mem_pipe_reg

Parametrised EX→MEM pipeline boundary register for the core. It carries the execute-stage result bundle (rd, store data, ALU/CFU result, pc+4, LSU op and write-back controls) from the execute stage to the memory stage under a valid/ready handshake. It supports a synchronous flush for branch redirects and a selectable skid-buffer mode that registers the upstream `in_ready`, breaking the combinational ready path.

## Interface
- `XLEN`, 32: datapath width of `opr_b`, `opr_res` and `pc4`.
- `LSUOP_W`, 4: width of the LSU op code field; must match the lsuop enum width.
- `SKID`, 1: 1 selects a 2-entry skid buffer with registered `in_ready`; 0 selects a single register with combinational `in_ready`.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `arst_n`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  drops all held entries and any same-cycle input transfer.
- `in_valid`  in  1  upstream bundle valid.
- `in_ready`  out  1  block can accept a bundle.
- `in_rd`  in  5  destination register.
- `in_opr_b`  in  XLEN  store data.
- `in_opr_res`  in  XLEN  ALU/CFU result or address.
- `in_pc4`  in  XLEN  pc+4 for link write-back.
- `in_lsuop`  in  LSUOP_W  LSU operation.
- `in_rf_en`, `in_dm_en`  in  1 each  register-file write enable and data-memory enable.
- `in_wb_sel`  in  2  write-back source select.
- `out_valid`  out  1  downstream bundle valid.
- `out_ready`  in  1  downstream accepts.
- `out_rd`, `out_opr_b`, `out_opr_res`, `out_pc4`, `out_lsuop`, `out_rf_en`, `out_dm_en`, `out_wb_sel`  out  same widths as inputs  registered bundle.
- `occupancy`  out  2  number of held entries (0..2; never exceeds 1 when SKID=0).

## Operation
- A transfer in: `in_valid & in_ready` at the edge. A transfer out: `out_valid & out_ready` at the edge.
- Bundles leave in strict arrival order. No bundle is duplicated or dropped except by `flush`.
- **SKID=0**
  - Single main register.
  - `in_ready = ~main_valid | out_ready` (combinational).
  - On a transfer in, main loads the input and `main_valid` sets.
  - On a transfer out with no transfer in, `main_valid` clears.
- **SKID=1**
  - Holds a main entry, which drives `out_*`, and a skid entry.
  - `in_ready = ~skid_valid`, driven from a flop.
  - State is given by {main_valid, skid_valid}: EMPTY {0,0}, ONE {1,0}, FULL {1,1}.
  - EMPTY, transfer in → ONE; main loads the input.
  - ONE, transfer in with transfer out → ONE; main loads the input.
  - ONE, transfer in without transfer out → FULL; skid loads the input.
  - ONE, transfer out without transfer in → EMPTY.
  - FULL, transfer out → ONE; main loads from skid. No transfer in is possible because `in_ready=0`.
  - FULL, no transfer out → hold.
- **Flush**
  - At the edge, both valid flags clear and `occupancy` becomes 0.
  - Any same-cycle transfer in is discarded.
  - Any same-cycle transfer out still counts as consumed downstream; the block does not retract `out_valid` combinationally.
  - Flush has priority over all other events.
- Payload registers update only on load. A payload whose valid flag is 0 holds its last value and is don't-care.
- `occupancy = main_valid + skid_valid`.

## Timing
- **Reset:** all valid flags are 0 and all `out_*` payload fields are 0. `out_valid=0` and `occupancy=0`. `in_ready=1` while in reset and on the first edge after release, in both modes.
- **Latency:** an input accepted at edge N appears on `out_*` with `out_valid=1` after edge N, i.e. 1 cycle. This holds in both modes when main is empty or being drained.
- **Throughput:** 1 bundle/cycle sustained while `out_ready=1`, in both modes.
- **SKID=1 backpressure:** `out_ready` low while ONE with a transfer in → FULL, and `in_ready` drops the cycle after. At most one extra bundle is absorbed after backpressure is asserted.
- **SKID=1 release:** `out_ready` high while FULL → `in_ready` returns to 1 the cycle after.
- **SKID=0:** `in_ready` follows `out_ready` combinationally; there is no skid storage.
- `out_valid`, once asserted, stays asserted with a stable payload until a transfer out or `flush`.
- Asynchronous reset mid-transfer clears all state immediately. No partial bundle survives.

## Test plan
- **Reset:** assert `arst_n=0` mid-stream with FULL state → immediately `out_valid=0`, `occupancy=0`, `out_opr_res=0`; `in_ready=1`.
- **Streaming, SKID=1, `out_ready=1`:** send 8 bundles with `opr_res`=0x10..0x17 on consecutive cycles → outputs 0x10..0x17 in order, each 1 cycle after input, no bubbles.
- **Backpressure, SKID=1:** hold `out_ready=0` and send 0xA, 0xB, 0xC → 0xA on out, 0xB in skid, `occupancy=2`, `in_ready=0`, 0xC not accepted. Raise `out_ready` → 0xA, 0xB, 0xC emerge in order.
- **Flush on FULL with simultaneous `in_valid`** (`in_ready=0`, so nothing accepted) → next cycle `out_valid=0`, `occupancy=0`, `in_ready=1`; flushed bundles never appear.
- **Flush with a transfer in at ONE:** input `rd=5`, `opr_res=0x123` is discarded → `out_valid=0` next cycle.
- **SKID=0, toggling `out_ready`:** `in_ready` equals `~out_valid | out_ready` every cycle, `occupancy` ≤ 1, and `opr_b`/`pc4` with XLEN=64 values (e.g. 0xFFFF_0000_1234_5678) pass unaltered.
